// File: rtl/lc3b_types.sv
// Shared LC-3b datapath/cache types used by the store merge buffer, merge mux and cache.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_8words;
  typedef logic [15:0]  lc3b_bytemask;

  typedef enum logic [2:0] {
    SMB_EMPTY,
    SMB_COLLECT,
    SMB_FETCH,
    SMB_MERGE,
    SMB_WRITE
  } smb_state_t;

endpackage

// File: rtl/smb_byte_lane.sv
// One byte of the write-combining line: data register plus its valid bit.
module smb_byte_lane (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we_i,
  input  logic       clr_i,
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  output logic       valid_o
);

  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (we_i) begin
      data_d  = data_i;
      valid_d = 1'b1;
    end else if (clr_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/store_merge_buffer.sv
// Single-line write-combining buffer: collects stores to one 16-byte line, then
// fetches the backing line (unless fully written), captures the merge and writes it back.
module store_merge_buffer
  import lc3b_types::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cpu_write,
  input  logic [15:0]  cpu_address,
  input  logic [15:0]  cpu_wdata,
  input  logic [1:0]   cpu_byte_enable,
  output logic         cpu_resp,
  input  logic         flush,
  output logic         idle,
  output logic         pending_valid,
  output logic [11:0]  pending_tag,
  output logic [15:0]  cpu_sel,
  output logic [127:0] dat_i_cpu,
  output logic [127:0] dat_o_cpu,
  input  logic [127:0] merged_line,
  output logic         mem_read,
  output logic         mem_write,
  output logic [15:0]  mem_address,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_resp
);

  smb_state_t   state_q, state_d;
  logic [11:0]  tag_q, tag_d;
  logic [15:0]  idle_cnt_q, idle_cnt_d;
  logic         cpu_resp_q, cpu_resp_d;
  lc3b_8words   line_q, line_d;
  lc3b_8words   wdata_q, wdata_d;
  lc3b_bytemask mask;

  logic store_req, tag_hit, accept, mask_full, timeout_hit, drain, clr;
  logic unused_addr0;

  assign unused_addr0 = cpu_address[0];

  if (TIMEOUT == 0) begin : g_no_timeout
    assign timeout_hit = 1'b0;
  end else begin : g_timeout
    assign timeout_hit = (idle_cnt_q == 16'(TIMEOUT - 1));
  end

  // The request held during its own cpu_resp cycle is the one just taken; ignore it.
  always_comb begin
    tag_hit   = (cpu_address[15:4] == tag_q);
    store_req = cpu_write && !cpu_resp_q;
    accept    = store_req && ((state_q == SMB_EMPTY) ||
                              ((state_q == SMB_COLLECT) && tag_hit));
    mask_full = (mask == '1);
    drain     = (store_req && !tag_hit) || flush || timeout_hit || mask_full;
    clr       = (state_q == SMB_WRITE) && mem_resp;
  end

  always_comb begin
    state_d    = state_q;
    tag_d      = accept ? cpu_address[15:4] : tag_q;
    cpu_resp_d = accept;
    idle_cnt_d = ((state_q == SMB_COLLECT) && !accept) ? idle_cnt_q + 16'd1 : '0;
    line_d     = ((state_q == SMB_FETCH) && mem_resp) ? mem_rdata : line_q;
    wdata_d    = (state_q == SMB_MERGE) ? merged_line : wdata_q;
    unique case (state_q)
      SMB_EMPTY:   if (accept) state_d = SMB_COLLECT;
      // An accepted store wins over any trigger; the drain starts a cycle later.
      SMB_COLLECT: if (!accept && drain) state_d = mask_full ? SMB_MERGE : SMB_FETCH;
      SMB_FETCH:   if (mem_resp) state_d = SMB_MERGE;
      SMB_MERGE:   state_d = SMB_WRITE;
      SMB_WRITE:   if (mem_resp) state_d = SMB_EMPTY;
      default:     state_d = SMB_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SMB_EMPTY;
      tag_q      <= '0;
      idle_cnt_q <= '0;
      cpu_resp_q <= 1'b0;
      line_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      tag_q      <= tag_d;
      idle_cnt_q <= idle_cnt_d;
      cpu_resp_q <= cpu_resp_d;
      line_q     <= line_d;
      wdata_q    <= wdata_d;
    end
  end

  for (genvar i = 0; i < 16; i++) begin : g_lane
    smb_byte_lane u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .we_i    (accept && (cpu_address[3:1] == 3'(i / 2)) && cpu_byte_enable[i % 2]),
      .clr_i   (clr),
      .data_i  ((i % 2 == 1) ? cpu_wdata[15:8] : cpu_wdata[7:0]),
      .data_o  (dat_i_cpu[8*i +: 8]),
      .valid_o (mask[i])
    );
  end

  assign cpu_resp      = cpu_resp_q;
  assign idle          = (state_q == SMB_EMPTY);
  assign pending_valid = (state_q != SMB_EMPTY);
  assign pending_tag   = tag_q;
  assign cpu_sel       = mask;
  assign dat_o_cpu     = line_q;
  assign mem_wdata     = wdata_q;
  assign mem_address   = {tag_q, 4'h0};
  assign mem_read      = (state_q == SMB_FETCH);
  assign mem_write     = (state_q == SMB_WRITE);

endmodule

// File: tb/tb_store_merge_buffer.sv
// Bench for store_merge_buffer: directed timing cases plus random stores scored against a line-image model.
module tb_store_merge_buffer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cpu_write = 1'b0;
  logic [15:0]  cpu_address = '0;
  logic [15:0]  cpu_wdata = '0;
  logic [1:0]   cpu_byte_enable = '0;
  logic         cpu_resp;
  logic         flush = 1'b0;
  logic         idle, pending_valid;
  logic [11:0]  pending_tag;
  logic [15:0]  cpu_sel;
  logic [127:0] dat_i_cpu, dat_o_cpu, merged_line;
  logic         mem_read, mem_write;
  logic [15:0]  mem_address;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata = '0;
  logic         mem_resp = 1'b0;

  always #5 clk = ~clk;

  store_merge_buffer #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_write(cpu_write), .cpu_address(cpu_address),
    .cpu_wdata(cpu_wdata), .cpu_byte_enable(cpu_byte_enable), .cpu_resp(cpu_resp),
    .flush(flush), .idle(idle), .pending_valid(pending_valid), .pending_tag(pending_tag),
    .cpu_sel(cpu_sel), .dat_i_cpu(dat_i_cpu), .dat_o_cpu(dat_o_cpu),
    .merged_line(merged_line), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_resp(mem_resp)
  );

  int n_chk = 0;
  int n_bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // External per-byte merge mux.
  always_comb begin
    merged_line = '0;
    for (int i = 0; i < 16; i++)
      merged_line[8*i +: 8] = cpu_sel[i] ? dat_i_cpu[8*i +: 8] : dat_o_cpu[8*i +: 8];
  end

  // Backing memory and responder (drives just after the clock edge).
  logic [127:0] mem_q [logic [11:0]];
  bit hold_mem = 1'b0;
  bit rand_lat = 1'b0;
  int wcnt = 0;
  int lat = 0;

  always @(posedge clk) begin
    #1;
    if (!(mem_read || mem_write) || hold_mem) begin
      mem_resp = 1'b0;
      wcnt = 0;
      lat = rand_lat ? int'($urandom_range(0, 2)) : 0;
    end else if (wcnt >= lat) begin
      mem_resp = 1'b1;
      if (mem_read) begin
        if (!mem_q.exists(mem_address[15:4])) mem_q[mem_address[15:4]] = rnd128();
        mem_rdata = mem_q[mem_address[15:4]];
      end
    end else begin
      mem_resp = 1'b0;
      wcnt++;
    end
  end

  // Reference model: the pending line as a byte array plus mask, scored at each writeback.
  bit           m_active = 1'b0;
  logic [11:0]  m_tag = '0;
  logic [7:0]   m_byte [16];
  logic [15:0]  m_mask = '0;
  bit           saw_fetch = 1'b0;
  int           n_writes = 0;
  int           n_reads = 0;
  logic [15:0]  last_wr_addr = '0;
  logic [127:0] exp_line, back_line;
  int           base;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_active  = 1'b0;
      m_mask    = '0;
      saw_fetch = 1'b0;
    end else begin
      if (mem_read || mem_write)
        chk("rw_exclusive", 128'(mem_read & mem_write), 128'(0));
      if (mem_read && mem_resp) begin
        saw_fetch = 1'b1;
        n_reads++;
      end
      if (mem_write && mem_resp) begin
        back_line = mem_q.exists(m_tag) ? mem_q[m_tag] : '0;
        for (int i = 0; i < 16; i++)
          exp_line[8*i +: 8] = m_mask[i] ? m_byte[i] : back_line[8*i +: 8];
        chk("sb_active", 128'(m_active), 128'(1));
        chk("sb_addr", 128'(mem_address), 128'({m_tag, 4'h0}));
        chk("sb_sel", 128'(cpu_sel), 128'(m_mask));
        chk("sb_fetch", 128'(saw_fetch), 128'(m_mask != 16'hFFFF));
        chk("sb_line", mem_wdata, exp_line);
        mem_q[m_tag] = mem_wdata;
        last_wr_addr = mem_address;
        n_writes++;
        m_active  = 1'b0;
        m_mask    = '0;
        saw_fetch = 1'b0;
      end
      if (cpu_resp) begin
        if (m_active) chk("sb_same_line", 128'(cpu_address[15:4]), 128'(m_tag));
        m_active = 1'b1;
        m_tag    = cpu_address[15:4];
        base     = (int'(cpu_address) % 16) / 2 * 2;
        if (cpu_byte_enable[0]) begin m_byte[base] = cpu_wdata[7:0];  m_mask[base] = 1'b1; end
        if (cpu_byte_enable[1]) begin m_byte[base + 1] = cpu_wdata[15:8]; m_mask[base + 1] = 1'b1; end
      end
    end
  end

  // Called at a negedge; drives a store and returns at the negedge of its cpu_resp cycle.
  task automatic store(input logic [15:0] a, input logic [15:0] d, input logic [1:0] be,
                       output int rc);
    bit ok;
    ok = 1'b0;
    rc = 0;
    cpu_address = a;
    cpu_wdata = d;
    cpu_byte_enable = be;
    cpu_write = 1'b1;
    for (int t = 0; t < 80; t++) begin
      @(negedge clk);
      if (cpu_resp) begin ok = 1'b1; rc = cyc; break; end
    end
    cpu_write = 1'b0;
    chk("store_ack", 128'(ok), 128'(1));
  endtask

  task automatic wait_req(input bit wr, output int at);
    bit ok;
    ok = 1'b0;
    at = 0;
    for (int t = 0; t < 80; t++) begin
      if (wr ? mem_write : mem_read) begin ok = 1'b1; at = cyc; break; end
      @(negedge clk);
    end
    if (wr) chk("wait_write", 128'(ok), 128'(1));
    else    chk("wait_read", 128'(ok), 128'(1));
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 80; t++) begin
      @(negedge clk);
      if (idle) begin ok = 1'b1; break; end
    end
    chk("wait_idle", 128'(ok), 128'(1));
  endtask

  logic [11:0] tag_pool [3] = '{12'hA00, 12'hA01, 12'hB37};

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rc, at, rd0, wr0, gap;
    logic [11:0] tg;
    repeat (3) @(negedge clk);
    chk("rst_idle", 128'(idle), 128'(1));
    chk("rst_pvalid", 128'(pending_valid), 128'(0));
    chk("rst_sel", 128'(cpu_sel), 128'(0));
    chk("rst_resp", 128'(cpu_resp), 128'(0));
    chk("rst_mread", 128'(mem_read), 128'(0));
    chk("rst_mwrite", 128'(mem_write), 128'(0));
    chk("rst_tag", 128'(pending_tag), 128'(0));
    chk("rst_dati", dat_i_cpu, 128'(0));
    chk("rst_dato", dat_o_cpu, 128'(0));
    chk("rst_wdata", mem_wdata, 128'(0));
    rst_n = 1'b1;

    // flush in EMPTY does nothing
    @(negedge clk);
    flush = 1'b1;
    repeat (5) @(negedge clk);
    chk("flush_empty_idle", 128'(idle), 128'(1));
    chk("flush_empty_rd", 128'(mem_read), 128'(0));
    flush = 1'b0;

    // two stores, flush, partial drain
    mem_q[12'h300] = {16{8'hEE}};
    @(negedge clk);
    store(16'h3000, 16'h1234, 2'b11, rc);
    @(negedge clk);
    store(16'h3005, 16'hAB00, 2'b10, rc);
    flush = 1'b1;
    wait_req(1'b1, at);
    chk("t1_write_lat", 128'(at - rc), 128'(3));
    chk("t1_addr", 128'(mem_address), 128'(16'h3000));
    chk("t1_sel", 128'(cpu_sel), 128'(16'h0023));
    chk("t1_wdata", 128'(mem_wdata[47:0]), 128'(48'hABEEEEEE1234));
    flush = 1'b0;
    @(negedge clk);
    chk("t1_empty", 128'(idle), 128'(1));

    // full line skips the fetch
    @(negedge clk);
    rd0 = n_reads;
    for (int w = 0; w < 8; w++) begin
      @(negedge clk);
      store(16'h4000 + 16'(2 * w), 16'($urandom()), 2'b11, rc);
    end
    wait_req(1'b1, at);
    chk("full_write_lat", 128'(at - rc), 128'(2));
    chk("full_sel", 128'(cpu_sel), 128'(16'hFFFF));
    chk("full_no_read", 128'(n_reads), 128'(rd0));
    wait_idle();

    // tag miss holds the new store until the old line is written
    @(negedge clk);
    store(16'h5000, 16'h5555, 2'b11, rc);
    @(negedge clk);
    wr0 = n_writes;
    store(16'h6000, 16'h6666, 2'b11, rc);
    chk("miss_one_write", 128'(n_writes), 128'(wr0 + 1));
    chk("miss_old_addr", 128'(last_wr_addr), 128'(16'h5000));
    chk("miss_new_tag", 128'(pending_tag), 128'(12'h600));
    wait_idle();

    // timeout
    @(negedge clk);
    store(16'h8000, 16'h8888, 2'b01, rc);
    wait_req(1'b0, at);
    chk("timeout_lat", 128'(at - rc), 128'(4));
    wait_idle();

    // flush together with a same-line store
    @(negedge clk);
    store(16'h7000, 16'h7777, 2'b11, rc);
    @(negedge clk);
    flush = 1'b1;
    store(16'h7002, 16'h00CD, 2'b01, rc);
    wait_req(1'b1, at);
    chk("simul_sel", 128'(cpu_sel), 128'(16'h0007));
    chk("simul_byte2", 128'(mem_wdata[23:16]), 128'(8'hCD));
    flush = 1'b0;
    wait_idle();

    // async reset during FETCH
    @(negedge clk);
    hold_mem = 1'b1;
    store(16'h9000, 16'h0099, 2'b01, rc);
    flush = 1'b1;
    wait_req(1'b0, at);
    #2 rst_n = 1'b0;
    #1;
    chk("rstf_mread", 128'(mem_read), 128'(0));
    chk("rstf_idle", 128'(idle), 128'(1));
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    flush = 1'b0;
    hold_mem = 1'b0;
    @(negedge clk);
    chk("rstf_idle_after", 128'(idle), 128'(1));
    chk("rstf_mask", 128'(cpu_sel), 128'(0));
    chk("rstf_pvalid", 128'(pending_valid), 128'(0));

    // random traffic
    rand_lat = 1'b1;
    for (int n = 0; n < 250; n++) begin
      gap = int'($urandom_range(0, 6));
      repeat (gap) @(negedge clk);
      @(negedge clk);
      tg = tag_pool[$urandom_range(0, 2)];
      if ($urandom_range(0, 11) == 0) begin
        for (int w = 0; w < 8; w++) begin
          store({tg, 3'(w), 1'b0}, 16'($urandom()), 2'b11, rc);
          @(negedge clk);
        end
      end else begin
        flush = ($urandom_range(0, 5) == 0);
        store({tg, 4'($urandom())}, 16'($urandom()), 2'($urandom()), rc);
        flush = 1'b0;
      end
    end
    flush = 1'b1;
    wait_idle();
    flush = 1'b0;
    @(negedge clk);
    chk("final_model_empty", 128'(m_active), 128'(0));
    chk("final_idle", 128'(idle), 128'(1));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
